// File: rtl/cordic_angle_sequencer.sv
// cordic_angle_sequencer: replays one I/Q symbol to the CORDIC rotator once per candidate
// angle of the selected APSK mode, with skewed direction bits and rotator-aligned output tags.
module cordic_angle_sequencer #(
    parameter int WL   = 18,
    parameter int IDXW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WL-1:0]   in_x,
    input  logic [WL-1:0]   in_y,
    input  logic [1:0]      mode,
    output logic            cor_en,
    output logic [WL-1:0]   cor_x,
    output logic [WL-1:0]   cor_y,
    output logic            cor_pre_rot,
    output logic            cor_angle_pre,
    output logic [3:0]      cor_a_lo,
    output logic [2:0]      cor_a_hi,
    output logic            tag_valid,
    output logic [IDXW-1:0] tag_idx,
    output logic            tag_last,
    output logic            busy
);
    // {pre_rot, angle_pre, a6..a0}; mode 0 at 0..3, mode 1 at 4..15, mode 2 at 16..31
    localparam logic [8:0] ROM [32] = '{
        9'h0A5, 9'h13C, 9'h07F, 9'h1E1, 9'h042, 9'h0B7, 9'h168, 9'h01D,
        9'h0F0, 9'h12B, 9'h056, 9'h1C9, 9'h034, 9'h0E7, 9'h19A, 9'h071,
        9'h10E, 9'h153, 9'h0C2, 9'h03B, 9'h1A4, 9'h06D, 9'h118, 9'h0D1,
        9'h07A, 9'h1F3, 9'h02E, 9'h145, 9'h0B0, 9'h169, 9'h01F, 9'h1D6
    };
    typedef enum logic {IDLE, RUN} state_t;
    state_t          state_q, state_d;
    logic [IDXW-1:0] k_q, k_d, kmax_q, kmax_d, ti0_q, ti1_q;
    logic [4:0]      base_q, base_d;
    logic [WL-1:0]   x_q, x_d, y_q, y_d;
    logic [2:0]      a_hi_q;
    logic [1:0]      tv_q, tl_q;
    logic            run, last, hs;
    logic [8:0]      word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = run ? ((last && !in_valid) ? IDLE : RUN) : (hs ? RUN : IDLE);
        k_d     = (run && !last) ? k_q + 1'b1 : '0;
        x_d     = hs ? in_x : x_q;
        y_d     = hs ? in_y : y_q;
        base_d  = hs ? (mode == 2'd1 ? 5'd4 : mode == 2'd2 ? 5'd16 : 5'd0) : base_q;
        kmax_d  = hs ? (mode == 2'd1 ? IDXW'(11) : mode == 2'd2 ? IDXW'(15) : IDXW'(3)) : kmax_q;
    end

    always_comb begin
        run           = state_q == RUN;
        last          = run && k_q == kmax_q;
        in_ready      = !rst && (!run || last);
        hs            = in_valid && in_ready;
        word          = ROM[base_q + 5'(k_q)];
        cor_en        = run;
        cor_x         = x_q;
        cor_y         = y_q;
        cor_pre_rot   = run && word[8];
        cor_angle_pre = run && word[7];
        cor_a_lo      = run ? word[3:0] : '0;
        cor_a_hi      = a_hi_q;
        tag_valid     = tv_q[1];
        tag_idx       = ti1_q;
        tag_last      = tl_q[1];
        busy          = run || |tv_q;
    end

    // Upper direction bits and tags trail issue to match the rotator's internal pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q    <= '0;
            kmax_q <= '0;
            base_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
            a_hi_q <= '0;
            tv_q   <= '0;
            tl_q   <= '0;
            ti0_q  <= '0;
            ti1_q  <= '0;
        end else begin
            k_q    <= k_d;
            kmax_q <= kmax_d;
            base_q <= base_d;
            x_q    <= x_d;
            y_q    <= y_d;
            a_hi_q <= run ? word[6:4] : '0;
            tv_q   <= {tv_q[0], run};
            tl_q   <= {tl_q[0], last};
            ti0_q  <= k_q;
            ti1_q  <= ti0_q;
        end
    end
endmodule

// File: tb/tb_cordic_angle_sequencer.sv
// tb_cordic_angle_sequencer: directed vectors against a hand-written angle table and timing.
module tb_cordic_angle_sequencer;
    logic        clk = 0, rst = 1, in_valid = 0;
    logic [1:0]  mode = 0;
    logic [17:0] in_x = 0, in_y = 0;
    logic        in_ready, cor_en, cor_pre_rot, cor_angle_pre, tag_valid, tag_last, busy;
    logic [17:0] cor_x, cor_y;
    logic [3:0]  cor_a_lo, tag_idx;
    logic [2:0]  cor_a_hi;
    int          tests = 0, fails = 0;

    logic [8:0] rom [32] = '{
        9'h0A5, 9'h13C, 9'h07F, 9'h1E1, 9'h042, 9'h0B7, 9'h168, 9'h01D,
        9'h0F0, 9'h12B, 9'h056, 9'h1C9, 9'h034, 9'h0E7, 9'h19A, 9'h071,
        9'h10E, 9'h153, 9'h0C2, 9'h03B, 9'h1A4, 9'h06D, 9'h118, 9'h0D1,
        9'h07A, 9'h1F3, 9'h02E, 9'h145, 9'h0B0, 9'h169, 9'h01F, 9'h1D6
    };

    typedef struct {
        logic [1:0]  mode;
        logic [17:0] x, y;
        int          base, cnt;
        bit          tog;
    } vec_t;
    vec_t vecs [4];

    cordic_angle_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .mode(mode), .cor_en(cor_en),
        .cor_x(cor_x), .cor_y(cor_y), .cor_pre_rot(cor_pre_rot),
        .cor_angle_pre(cor_angle_pre), .cor_a_lo(cor_a_lo), .cor_a_hi(cor_a_hi),
        .tag_valid(tag_valid), .tag_idx(tag_idx), .tag_last(tag_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Starts at a negedge in IDLE; ends at the negedge after the tag pipeline drains
    task automatic run_sym(input vec_t v);
        logic [8:0] w;
        chk("idle_ready", in_ready, 1);
        in_valid = 1; mode = v.mode; in_x = v.x; in_y = v.y;
        @(negedge clk);
        in_valid = 0;
        for (int c = 0; c < v.cnt + 3; c++) begin
            chk("cor_x", cor_x, v.x);
            chk("cor_y", cor_y, v.y);
            chk("busy", busy, c <= v.cnt + 1);
            if (c < v.cnt) begin
                w = rom[v.base + c];
                chk("cor_en", cor_en, 1);
                chk("a_lo", cor_a_lo, w[3:0]);
                chk("pre_rot", cor_pre_rot, w[8]);
                chk("angle_pre", cor_angle_pre, w[7]);
                chk("run_ready", in_ready, c == v.cnt - 1);
            end else begin
                chk("cor_en_off", cor_en, 0);
                chk("a_lo_off", cor_a_lo, 0);
            end
            if (c >= 1 && c <= v.cnt) begin
                w = rom[v.base + c - 1];
                chk("a_hi", cor_a_hi, w[6:4]);
            end else chk("a_hi_zero", cor_a_hi, 0);
            if (c >= 2 && c <= v.cnt + 1) begin
                chk("tag_valid", tag_valid, 1);
                chk("tag_idx", tag_idx, c - 2);
                chk("tag_last", tag_last, c - 2 == v.cnt - 1);
            end else chk("tag_idle", tag_valid, 0);
            if (v.tog && c == 3) begin
                mode = 2'd2; in_x = ~v.x; in_y = ~v.y;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        vecs[0] = '{mode: 2'd0, x: 18'h00400, y: 18'h3FC00, base: 0,  cnt: 4,  tog: 0};
        vecs[1] = '{mode: 2'd2, x: 18'h12345, y: 18'h2ABCD, base: 16, cnt: 16, tog: 0};
        vecs[2] = '{mode: 2'd1, x: 18'h3FFFF, y: 18'h00001, base: 4,  cnt: 12, tog: 1};
        vecs[3] = '{mode: 2'd3, x: 18'h20000, y: 18'h1FFFF, base: 0,  cnt: 4,  tog: 0};

        @(negedge clk); @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_en", cor_en, 0);
        chk("rst_x", cor_x, 0);
        chk("rst_tag", tag_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_a_hi", cor_a_hi, 0);
        rst = 0;
        @(negedge clk);

        foreach (vecs[i]) run_sym(vecs[i]);

        // Back-to-back mode 2 then mode 1 with in_valid held
        begin
            int lasts = 0;
            logic [8:0] w;
            in_valid = 1; mode = 2'd2; in_x = 18'h0AAAA; in_y = 18'h15555;
            @(negedge clk);
            for (int i = 0; i < 32; i++) begin
                if (i < 28) begin
                    w = rom[i < 16 ? 16 + i : i - 12];
                    chk("b2b_en", cor_en, 1);
                    chk("b2b_ready", in_ready, i == 15 || i == 27);
                    chk("b2b_a_lo", cor_a_lo, w[3:0]);
                    chk("b2b_x", cor_x, i < 16 ? 18'h0AAAA : 18'h33333);
                end else chk("b2b_en_off", cor_en, 0);
                if (tag_last) lasts++;
                if (i == 15) begin mode = 2'd1; in_x = 18'h33333; in_y = 18'h0CCCC; end
                if (i == 27) in_valid = 0;
                @(negedge clk);
            end
            chk("b2b_lasts", lasts, 2);
        end

        // Reset at k=5 of a mode-2 symbol
        in_valid = 1; mode = 2'd2; in_x = 18'h11111; in_y = 18'h22222;
        @(negedge clk);
        in_valid = 0;
        repeat (5) @(negedge clk);
        chk("pre_rst_en", cor_en, 1);
        rst = 1;
        #1;
        chk("arst_en", cor_en, 0);
        chk("arst_x", cor_x, 0);
        chk("arst_a_lo", cor_a_lo, 0);
        chk("arst_a_hi", cor_a_hi, 0);
        chk("arst_tag", tag_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", in_ready, 0);
        @(negedge clk); @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_tag", tag_valid, 0);
            chk("post_rst_en", cor_en, 0);
        end
        run_sym(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
